// File: rtl/myproject_dense_acc_requant.sv
// myproject_dense_acc_requant
//   Dense-layer accumulate + requantize stage. Sums N_IN signed product terms
//   (PROD_W bits, FRAC_SHIFT more fractional bits than the output) plus a
//   per-neuron bias, rounds half-up, saturates to OUT_W, optional ReLU, and
//   hands one result per neuron to the next stage.
// Ports:
//   ap_clk, ap_rst            clock / async active-high reset
//   in_data/in_valid/in_last  product term stream, in_ready back-pressures it
//   bias                      neuron bias, taken with the first term only
//   out_data/out_valid        result, held until out_ready
//   err_last                  sticky: in_last disagreed with the term count
module myproject_dense_acc_requant #(
  parameter int N_IN       = 16,
  parameter int PROD_W     = 26,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int RELU       = 0
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [PROD_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic signed [OUT_W-1:0]  bias,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err_last
);

  localparam int CNT_W = $clog2(N_IN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // One extra bit on the rounding path so adding the half-LSB never wraps.
  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) <<< (FRAC_SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX  = {{(ACC_W+1-OUT_W){1'b0}}, 1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN  = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [0:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;

  logic                     accept;
  logic                     last_term;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    shf;
  logic signed [OUT_W-1:0]  sat;
  logic signed [OUT_W-1:0]  res;

  assign in_ready  = (state == ST_ACCUM) && !ap_rst;
  assign accept    = in_valid && in_ready;
  assign last_term = (cnt == CNT_LAST);

  // Bias is aligned to the product binary point so it joins the sum exactly.
  assign bias_ext = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias} <<< FRAC_SHIFT;
  assign prod_ext = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
  assign base     = (cnt == '0) ? bias_ext : acc;
  assign sum      = base + prod_ext;
  assign rnd      = {sum[ACC_W-1], sum} + RND_HALF;
  assign shf      = rnd >>> FRAC_SHIFT;

  always_comb begin
    sat = shf[OUT_W-1:0];
    if (shf > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
    else if (shf < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
    res = sat;
    if (RELU != 0 && sat[OUT_W-1]) res = '0;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= ST_ACCUM;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err_last  <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            // Grouping is purely by count; in_last is only cross-checked.
            if (in_last != last_term) err_last <= 1'b1;
            if (last_term) begin
              out_data  <= res;
              out_valid <= 1'b1;
              cnt       <= '0;
              state     <= ST_HOLD;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_dense_acc_requant.sv
// Directed + randomized bench for myproject_dense_acc_requant (N_IN=4).
// Two instances share the stimulus: one plain, one with RELU enabled.
module tb_myproject_dense_acc_requant;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b0;
  logic signed [25:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic signed [15:0] bias = '0;
  logic               out_ready = 1'b1;
  logic               in_ready, in_ready_r;
  logic signed [15:0] out_data, out_data_r;
  logic               out_valid, out_valid_r;
  logic               err_last, err_last_r;

  int     vectors = 0;
  int     errs = 0;
  bit     exp_err = 0;
  longint p[4];
  longint held;

  always #5 ap_clk = ~ap_clk;

  myproject_dense_acc_requant #(.N_IN(4), .RELU(0)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .bias(bias), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err_last(err_last));

  myproject_dense_acc_requant #(.N_IN(4), .RELU(1)) dut_r (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_r), .bias(bias), .out_data(out_data_r),
    .out_valid(out_valid_r), .out_ready(out_ready), .err_last(err_last_r));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact real-valued sum, round half up, clamp, optional ReLU.
  function automatic longint ref_out(input longint b, input longint psum, input bit relu);
    longint s, r;
    s = b * 1024 + psum;
    r = (s + 512) >>> 10;          // floor((s + 512) / 1024)
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r;
  endfunction

  // Offer one term at a negedge, wait for it to be accepted, return at the
  // negedge after the accepting edge.
  task automatic push(input longint d, input bit l, input longint b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge ap_clk);
    in_valid = 1'b1;
    in_data  = 26'(d);
    in_last  = l;
    bias     = 16'(b);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge ap_clk);
      t++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
  endtask

  // Sends p[0..3]; in_last is raised on term lastpos. Non-first terms carry
  // junk bias, which must be ignored.
  task automatic group(input longint b, input int lastpos, input bit hold, input bit gaps,
                       input string tag, output longint eo);
    longint s, er;
    bit l;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      l = (i == lastpos);
      push(p[i], l, (i == 0) ? b : longint'($urandom_range(0, 65535)) - 32768,
           gaps ? int'($urandom_range(0, 2)) : 0);
      if (l != (i == 3)) exp_err = 1;
      s += p[i];
    end
    eo = ref_out(b, s, 0);
    er = ref_out(b, s, 1);
    chk({tag, "_data"}, out_data, eo);
    chk({tag, "_data_relu"}, out_data_r, er);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_valid_relu"}, out_valid_r, 1);
    chk({tag, "_ready_low"}, in_ready, 0);
    chk({tag, "_err"}, err_last, exp_err);
    chk({tag, "_err_relu"}, err_last_r, exp_err);
    if (!hold) begin
      @(negedge ap_clk);
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_ready_back"}, in_ready, 1);
      chk({tag, "_ready_back_relu"}, in_ready_r, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [25:0] rp;
    logic signed [15:0] rb;
    longint e;

    // Reset state
    #1 ap_rst = 1'b1;
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err_last, 0);
    chk("rst_in_ready", in_ready, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rel_in_ready", in_ready, 1);

    // Basic sum, latency and single-cycle in_ready drop
    p = '{1024, 1024, 1024, 1024};
    group(0, 3, 0, 0, "basic", e);
    chk("basic_is4", e, 4);

    // Rounding
    p = '{512, 0, 0, 0};   group(0, 3, 0, 0, "rnd_p512", e);
    p = '{-512, 0, 0, 0};  group(0, 3, 0, 0, "rnd_m512", e);
    p = '{-513, 0, 0, 0};  group(0, 3, 0, 0, "rnd_m513", e);
    p = '{511, 0, 0, 0};   group(0, 3, 0, 0, "rnd_p511", e);

    // Bias, saturation, ReLU
    p = '{0, 0, 0, 0};     group(3, 3, 0, 0, "bias3", e);
    p = '{33554431, 33554431, 33554431, 33554431};
    group(0, 3, 0, 0, "sat_hi", e);
    p = '{-33554432, -33554432, -33554432, -33554432};
    group(0, 3, 0, 0, "sat_lo", e);
    p = '{0, 0, 0, 0};     group(-5, 3, 0, 0, "relu_m5", e);

    // Randomized groups with bubbles
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < 4; i++) begin
        rp = 26'($urandom);
        p[i] = rp;
      end
      rb = 16'($urandom);
      group(rb, 3, 0, 1, "rand", e);
    end

    // Backpressure with the next term waiting on in_valid
    out_ready = 1'b0;
    p = '{1000, 2000, -3000, 4096};
    group(7, 3, 1, 0, "bp_a", held);
    in_valid = 1'b1; in_data = 26'(5000); bias = 16'(-2); in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      chk("bp_hold_data", out_data, held);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    p = '{5000, -700, 123456, -9};
    group(-2, 3, 0, 0, "bp_b", e);

    // in_last on 2nd term: sticky error, grouping unchanged
    p = '{100, 200, 300, 400};
    group(2, 1, 0, 0, "lastmis", e);
    p = '{2048, 0, 0, 0};
    group(0, 3, 0, 0, "lastmis_after", e);

    // Async reset while holding a result
    out_ready = 1'b0;
    p = '{30000, 40000, 50000, 60000};
    group(9, 3, 1, 0, "hold_rst", e);
    #2 ap_rst = 1'b1;
    #1;
    chk("hrst_valid", out_valid, 0);
    chk("hrst_data", out_data, 0);
    chk("hrst_data_relu", out_data_r, 0);
    chk("hrst_err", err_last, 0);
    chk("hrst_ready", in_ready, 0);
    exp_err = 0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    out_ready = 1'b1;

    // Async reset after 2 of 4 terms
    push(777777, 0, 100, 0);
    push(-55555, 0, 0, 0);
    #2 ap_rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", in_ready, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    p = '{1024, 1024, 1024, 1024};
    group(1, 3, 0, 0, "post_rst", e);
    chk("post_rst_is5", e, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/myproject_dense_acc_requant.md
Name: myproject_dense_acc_requant

Overview:
- Downstream consumer of the 16s x 10s -> 26-bit signed product stage in the dense-layer datapath.
- Accumulates N_IN consecutive 26-bit products into one neuron sum and adds a per-neuron bias.
- Rounds and saturates the sum back to the 16-bit activation format.
- Emits one result per neuron over a valid/ready handshake to the next layer stage.

Parameters:
- N_IN, 16: products summed per output (>=2).
- PROD_W, 26: product width, signed, 20 fractional bits.
- ACC_W, 32: accumulator width; must be >= PROD_W+clog2(N_IN)+1.
- OUT_W, 16: output and bias width, signed, 10 fractional bits.
- FRAC_SHIFT, 10: product fractional bits minus output fractional bits.
- RELU, 0: 1 clamps negative results to 0 after saturation.

Ports:
- ap_clk  in  1  clock, all state on rising edge.
- ap_rst  in  1  asynchronous active-high reset.
- in_data  in  PROD_W  signed product term.
- in_valid  in  1  in_data valid.
- in_last  in  1  producer marks final term of a neuron.
- in_ready  out  1  block accepts a term this cycle.
- bias  in  OUT_W  signed bias, sampled with the first term of each neuron.
- out_data  out  OUT_W  signed rounded/saturated result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- err_last  out  1  sticky: in_last disagreed with the term count.

Behaviour:
- Reset (async, ap_rst=1): state=ACCUM, cnt=0, acc=0, out_data=0, out_valid=0, err_last=0. in_ready=0 while ap_rst is high; in_ready=1 from the first cycle after release.
- Accept: a term is accepted when in_valid && in_ready. in_ready = (state==ACCUM).
- States: ACCUM and HOLD.
- ACCUM, cnt==0 accept: acc = sext(bias)<<FRAC_SHIFT + sext(in_data); cnt=1.
- ACCUM, 0<cnt<N_IN-1 accept: acc += sext(in_data); cnt++.
- ACCUM, cnt==N_IN-1 accept:
  - Final sum s = acc + in_data.
  - r = (s + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, arithmetic shift, round-half-up.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then apply RELU if enabled.
  - Register result into out_data; out_valid=1; cnt=0; go to HOLD.
- Latency: out_valid rises the cycle after the last term is accepted.
- HOLD: in_ready=0; out_data and out_valid stay stable until out_ready=1. On that cycle out_valid drops and state returns to ACCUM; the next term can be accepted the following cycle. No output skid, so throughput is N_IN+1 cycles per neuron with out_ready held high.
- in_valid low in ACCUM: no state change (bubbles allowed mid-group).
- in_last check:
  - Set err_last if in_last=1 on an accepted term with cnt!=N_IN-1, or in_last=0 on the term with cnt==N_IN-1.
  - The grouping is always by count, never by in_last.
  - err_last clears only on reset.
- Intermediate accumulation cannot overflow given the ACC_W rule. Overflow handling happens only at the saturation step.
- bias is ignored except on the cnt==0 accepting cycle.
- Reset mid-group or in HOLD: the partial sum and any pending output are discarded, with all values as listed under Reset.

Test Plan:
- N_IN=4, bias=0, products 1024,1024,1024,1024, out_ready=1:
  - sum 4096 -> out_data=4.
  - out_valid exactly 1 cycle after the 4th accept.
  - in_ready low exactly 1 cycle.
- Rounding, N_IN=4, bias=0:
  - Products 512,0,0,0 -> 1.
  - Products -512,0,0,0 -> 0.
  - Products -513,0,0,0 -> -1.
  - Products 511,0,0,0 -> 0.
- Bias and saturation, N_IN=4:
  - bias=3, products all 0 -> 3.
  - bias=0, products all 33554431 -> 32767.
  - bias=0, products all -33554432 -> -32768.
  - RELU=1, bias=-5, products 0 -> 0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid.
  - out_data stays stable, in_ready=0, and in_valid held high is not consumed.
  - out_ready=1 -> handshake completes, next group starts the cycle after, and no term is lost or duplicated.
- in_last mismatch: assert in_last on the 2nd term of a group -> err_last=1 from the next cycle, group still closes on the 4th term, err_last persists until ap_rst.
- Async reset after 2 of 4 terms:
  - Outputs clear immediately, without waiting for a clock edge.
  - The next full group with bias=1, products 1024×4 -> 5, with no residue from the aborted group.
